// File: rtl/mii_rx_deframer_pkg.sv
// Shared types and constants for the MII/GMII receive deframer.
package mii_rx_deframer_pkg;

    localparam int unsigned MAX_ETH_FRAME_CNT = 1518;
    localparam logic [31:0] CRC32_POLY        = 32'h04C11DB7;
    localparam logic [31:0] CRC32_RESIDUE     = 32'hC704DD7B;

    typedef enum logic [1:0] {LINK_10, LINK_100, LINK_1000} link_speed_t;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;

    typedef struct packed {
        logic rx_fl;
        logic crc_val;
        logic line_err;
    } mii_rx_status_t;

    typedef struct packed {
        logic [7:0] sfd_err_cnt;
        logic [7:0] false_carrier_cnt;
        logic [7:0] align_err_cnt;
    } rx_deframer_status_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/interSw.sv
// Switch-level clock, reset and link speed bundle.
interface interSw;
    logic                             clk;
    logic                             main_rst_n;
    mii_rx_deframer_pkg::link_speed_t link_speed;

    modport ethSw (input clk, input main_rst_n, input link_speed);
endinterface

// File: rtl/crc32_d8.sv
// One-byte CRC-32 update, MSB-first register fed with data LSB first.
module crc32_d8
    import mii_rx_deframer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC32_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII/GMII receive deframer: strips preamble/SFD, delivers bytes, checks FCS.
module mii_rx_deframer
    import mii_rx_deframer_pkg::*;
#(
    parameter int unsigned pMAX_BYTES  = MAX_ETH_FRAME_CNT + 4,
    parameter logic        pIGNORE_CRC = 1'b0
) (
    interSw.ethSw               ethSw,
    input  logic                rx_ce,
    input  logic                rx_dv,
    input  logic                rx_er,
    input  logic [7:0]          rxd,
    output logic                valid_rx,
    output logic [7:0]          data_rx,
    output mii_rx_status_t      rx_stat,
    output rx_deframer_status_t status
);

    localparam int unsigned CNT_W = $clog2(pMAX_BYTES + 1);

    logic             clk;
    logic             rst_n;
    rx_state_t        state, state_nxt;
    logic             nibble_mode;
    logic             first_ce;
    logic             seen5;
    logic             have_low;
    logic [3:0]       low_nib;
    logic             err_seen;
    logic             drop_fl;
    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      crc, crc_next;
    logic [7:0]       byte_val;
    logic             is_pre, is_sfd;
    logic             enter_data, deliver, store_low, overflow, report;
    logic             fc_inc, sfd_inc;

    assign clk      = ethSw.clk;
    assign rst_n    = ethSw.main_rst_n;
    assign byte_val = nibble_mode ? {rxd[3:0], low_nib} : rxd;
    assign is_pre   = nibble_mode ? (rxd[3:0] == 4'h5) : (rxd == 8'h55);
    assign is_sfd   = nibble_mode ? (rxd[3:0] == 4'hD && seen5) : (rxd == 8'hD5);

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (byte_val),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        enter_data = 1'b0;
        deliver    = 1'b0;
        store_low  = 1'b0;
        overflow   = 1'b0;
        report     = 1'b0;
        fc_inc     = 1'b0;
        sfd_inc    = 1'b0;
        if (rx_ce) begin
            case (state)
                IDLE: if (rx_dv) begin
                    // the first strobe after reset may land mid-frame, so never join it
                    state_nxt = (rx_er || first_ce) ? DROP : PREAMBLE;
                    fc_inc    = rx_er;
                end
                PREAMBLE: begin
                    if (!rx_dv) state_nxt = IDLE;
                    else if (is_sfd) begin
                        state_nxt  = DATA;
                        enter_data = 1'b1;
                    end else if (!is_pre) begin
                        state_nxt = DROP;
                        sfd_inc   = 1'b1;
                    end
                end
                DATA: begin
                    if (!rx_dv) begin
                        state_nxt = IDLE;
                        report    = 1'b1;
                    end else if (nibble_mode && !have_low) store_low = 1'b1;
                    else if (byte_cnt >= CNT_W'(pMAX_BYTES)) begin
                        state_nxt = DROP;
                        overflow  = 1'b1;
                    end else deliver = 1'b1;
                end
                DROP: if (!rx_dv) begin
                    state_nxt = IDLE;
                    report    = drop_fl;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_rx    <= 1'b0;
            data_rx     <= '0;
            rx_stat     <= '0;
            status      <= '0;
            nibble_mode <= 1'b0;
            first_ce    <= 1'b1;
            seen5       <= 1'b0;
            have_low    <= 1'b0;
            low_nib     <= '0;
            err_seen    <= 1'b0;
            drop_fl     <= 1'b0;
            byte_cnt    <= '0;
            crc         <= '1;
        end else begin
            valid_rx <= deliver;
            rx_stat  <= '0;
            if (state == IDLE) nibble_mode <= (ethSw.link_speed != LINK_1000);
            if (rx_ce) first_ce <= 1'b0;
            if (rx_ce && state == IDLE) seen5 <= (rxd[3:0] == 4'h5);
            else if (rx_ce && state == PREAMBLE && is_pre) seen5 <= 1'b1;
            if (enter_data) begin
                crc      <= '1;
                byte_cnt <= '0;
                err_seen <= 1'b0;
                have_low <= 1'b0;
            end
            if (rx_ce && state == DATA && rx_dv && rx_er) err_seen <= 1'b1;
            if (store_low) begin
                low_nib  <= rxd[3:0];
                have_low <= 1'b1;
            end
            if (deliver) begin
                data_rx  <= byte_val;
                crc      <= crc_next;
                byte_cnt <= byte_cnt + CNT_W'(1);
                have_low <= 1'b0;
            end
            if (overflow) begin
                drop_fl  <= 1'b1;
                err_seen <= 1'b1;
                have_low <= 1'b0;
            end
            if (report) begin
                rx_stat.rx_fl    <= 1'b1;
                rx_stat.crc_val  <= pIGNORE_CRC || (crc == CRC32_RESIDUE);
                rx_stat.line_err <= err_seen || have_low;
                have_low         <= 1'b0;
                if (have_low) status.align_err_cnt <= sat_inc(status.align_err_cnt);
            end
            if (rx_ce && state == DROP && !rx_dv) drop_fl <= 1'b0;
            if (fc_inc)  status.false_carrier_cnt <= sat_inc(status.false_carrier_cnt);
            if (sfd_inc) status.sfd_err_cnt       <= sat_inc(status.sfd_err_cnt);
        end
    end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Scoreboard bench for mii_rx_deframer: GMII and MII frames, errors, overflow, reset.
module tb_mii_rx_deframer;
    import mii_rx_deframer_pkg::*;

    localparam int unsigned TB_MAX = 64;

    typedef struct {
        bit         is_fl;
        logic [7:0] data;
        logic       crc;
        logic       lerr;
    } exp_t;

    logic                clk;
    logic                rst_n;
    link_speed_t         speed;
    logic                rx_ce, rx_dv, rx_er;
    logic [7:0]          rxd;
    logic                valid_rx;
    logic [7:0]          data_rx;
    mii_rx_status_t      rx_stat;
    rx_deframer_status_t status;

    exp_t       exp_q[$];
    logic [7:0] frm[$];
    int         checks = 0;
    int         errors = 0;
    int         ce_period = 1;
    bit         mii = 1'b0;
    bit         spacing_on = 1'b0;
    int         cyc = 0;
    int         last_v = -1;

    interSw sw_if ();
    assign sw_if.clk        = clk;
    assign sw_if.main_rst_n = rst_n;
    assign sw_if.link_speed = speed;

    mii_rx_deframer #(.pMAX_BYTES(TB_MAX), .pIGNORE_CRC(1'b0)) dut (
        .ethSw    (sw_if),
        .rx_ce    (rx_ce),
        .rx_dv    (rx_dv),
        .rx_er    (rx_er),
        .rxd      (rxd),
        .valid_rx (valid_rx),
        .data_rx  (data_rx),
        .rx_stat  (rx_stat),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_refl(input int n);
        logic [31:0] r;
        r = '1;
        for (int i = 0; i < n; i++) begin
            r = r ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic build_frame(input int n);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'(i * 37 + 5));
        fcs = ~crc_refl(n);
        for (int i = 0; i < 4; i++) frm.push_back(fcs[8*i +: 8]);
    endtask

    task automatic sym(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk);
        rx_ce = 1'b1; rx_dv = dv; rx_er = er; rxd = d;
        for (int i = 1; i < ce_period; i++) begin
            @(negedge clk);
            rx_ce = 1'b0;
        end
    endtask

    task automatic send_byte(input logic dv, input logic er, input logic [7:0] b);
        if (!mii) sym(dv, er, b);
        else begin
            sym(dv, er, {4'h0, b[3:0]});
            sym(dv, er, {4'h0, b[7:4]});
        end
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) sym(1'b0, 1'b0, 8'h00);
    endtask

    task automatic tx_frame(input int er_at, input logic exp_crc, input logic exp_lerr, input bit extra_nib);
        int n_dl;
        n_dl = (frm.size() > TB_MAX) ? TB_MAX : frm.size();
        for (int i = 0; i < n_dl; i++) exp_q.push_back('{is_fl: 1'b0, data: frm[i], crc: 1'b0, lerr: 1'b0});
        exp_q.push_back('{is_fl: 1'b1, data: 8'h00, crc: exp_crc, lerr: exp_lerr});
        for (int i = 0; i < 7; i++) send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'hD5);
        foreach (frm[i]) send_byte(1'b1, (i == er_at), frm[i]);
        if (extra_nib) sym(1'b1, 1'b0, 8'h0A);
        idles(4);
    endtask

    // Monitor: every DUT output event must match the head of the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (valid_rx || rx_stat.rx_fl) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: valid_rx=%0b data_rx=%0h rx_fl=%0b with nothing expected (t=%0t)",
                             valid_rx, data_rx, rx_stat.rx_fl, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_fl) begin
                        check("rx_fl", {31'h0, rx_stat.rx_fl}, 32'd1);
                        check("valid_with_fl", {31'h0, valid_rx}, 32'd0);
                        check("crc_val", {31'h0, rx_stat.crc_val}, {31'h0, e.crc});
                        check("line_err", {31'h0, rx_stat.line_err}, {31'h0, e.lerr});
                        last_v = -1;
                    end else begin
                        check("valid_rx", {31'h0, valid_rx}, 32'd1);
                        check("data_rx", {24'h0, data_rx}, {24'h0, e.data});
                        if (spacing_on && last_v >= 0) check("strobe_spacing", cyc - last_v, 32'd8);
                        last_v = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d expected events pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; speed = LINK_1000;
        rx_ce = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid_rx", {31'h0, valid_rx}, 32'd0);
        check("rst_data_rx", {24'h0, data_rx}, 32'd0);
        check("rst_rx_stat", {29'h0, rx_stat}, 32'd0);
        check("rst_status", {8'h0, status}, 32'd0);
        rst_n = 1'b1;
        idles(4);

        // GMII good frame at exactly the byte limit
        build_frame(60);
        tx_frame(-1, 1'b1, 1'b0, 1'b0);
        // GMII single bit flip
        build_frame(60);
        frm[20] = frm[20] ^ 8'h10;
        tx_frame(-1, 1'b0, 1'b0, 1'b0);
        // rx_er on payload byte 10
        build_frame(60);
        tx_frame(10, 1'b1, 1'b1, 1'b0);

        // bad SFD, then a good frame
        send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'h57);
        send_byte(1'b1, 1'b0, 8'hD5);
        idles(4);
        check("sfd_err_cnt", {24'h0, status.sfd_err_cnt}, 32'd1);
        build_frame(60);
        tx_frame(-1, 1'b1, 1'b0, 1'b0);

        // false carrier
        sym(1'b1, 1'b1, 8'h0E);
        sym(1'b1, 1'b1, 8'h0E);
        idles(4);
        check("false_carrier_cnt", {24'h0, status.false_carrier_cnt}, 32'd1);

        // one byte over the limit: 64 delivered, then cut with line_err
        build_frame(61);
        tx_frame(-1, (crc_refl(TB_MAX) == 32'hDEBB20E3), 1'b1, 1'b0);

        // MII 100, rx_ce every 4 clk
        speed = LINK_100; mii = 1'b1; ce_period = 4;
        idles(3);
        spacing_on = 1'b1;
        build_frame(60);
        tx_frame(-1, 1'b1, 1'b0, 1'b0);
        spacing_on = 1'b0;
        // trailing odd nibble
        build_frame(60);
        tx_frame(-1, 1'b1, 1'b1, 1'b1);
        check("status_all", {8'h0, status}, {8'h0, 8'd1, 8'd1, 8'd1});

        // reset mid-payload, released while rx_dv is still high
        speed = LINK_1000; mii = 1'b0; ce_period = 1;
        idles(4);
        build_frame(60);
        for (int i = 0; i < 12; i++) exp_q.push_back('{is_fl: 1'b0, data: frm[i], crc: 1'b0, lerr: 1'b0});
        for (int i = 0; i < 7; i++) send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 12; i++) send_byte(1'b1, 1'b0, frm[i]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 12; i < 64; i++) begin
            sym(1'b1, 1'b0, frm[i]);
            if (i == 14) begin
                check("mid_rst_valid_rx", {31'h0, valid_rx}, 32'd0);
                check("mid_rst_data_rx", {24'h0, data_rx}, 32'd0);
                check("mid_rst_rx_stat", {29'h0, rx_stat}, 32'd0);
                check("mid_rst_status", {8'h0, status}, 32'd0);
            end
            if (i == 16) rst_n = 1'b1;
        end
        idles(4);
        check("post_rst_status", {8'h0, status}, 32'd0);
        build_frame(60);
        tx_frame(-1, 1'b1, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
